// File: rtl/fft8_sched.sv
// fft8_sched: 8-point radix-2 DIT FFT sequencer. It shares one external combinational
// complex multiplier across all 12 in-place butterflies of a bit-reversed sample buffer.
module fft8_sched #(
  parameter int DW    = 16,
  parameter int SCALE = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [DW-1:0] in_r,
  input  logic signed [DW-1:0] in_i,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [DW-1:0] out_r,
  output logic signed [DW-1:0] out_i,
  output logic [2:0]           out_idx,
  output logic                 busy,
  output logic signed [DW-1:0] mult_in_r,
  output logic signed [DW-1:0] mult_in_i,
  output logic signed [DW-1:0] mult_w_r,
  output logic signed [DW-1:0] mult_w_i,
  input  logic signed [DW-1:0] mult_out_r,
  input  logic signed [DW-1:0] mult_out_i
);

  typedef enum logic [1:0] {S_LOAD, S_COMPUTE, S_UNLOAD} state_t;

  state_t               r_state;
  logic [3:0]           r_cnt;
  logic                 r_in_ready;
  logic                 r_out_valid;
  logic                 r_busy;
  logic signed [DW-1:0] r_buf_r [8];
  logic signed [DW-1:0] r_buf_i [8];

  logic [1:0]           w_stage;
  logic [1:0]           w_bfly;
  logic [1:0]           w_k;
  logic [2:0]           w_top;
  logic [2:0]           w_bot;
  logic                 w_comp;
  logic signed [DW:0]   w_ar;
  logic signed [DW:0]   w_ai;
  logic signed [DW:0]   w_pr;
  logic signed [DW:0]   w_pi;
  logic signed [DW-1:0] w_sum_r;
  logic signed [DW-1:0] w_sum_i;
  logic signed [DW-1:0] w_dif_r;
  logic signed [DW-1:0] w_dif_i;

  function automatic logic [2:0] bitrev3(input logic [2:0] v);
    return {v[0], v[1], v[2]};
  endfunction

  // W8^k in Q8.8
  function automatic logic signed [DW-1:0] tw_r(input logic [1:0] k);
    case (k)
      2'd0:    return DW'(256);
      2'd1:    return DW'(181);
      2'd2:    return '0;
      default: return DW'(-181);
    endcase
  endfunction

  function automatic logic signed [DW-1:0] tw_i(input logic [1:0] k);
    case (k)
      2'd0:    return '0;
      2'd1:    return DW'(-181);
      2'd2:    return DW'(-256);
      default: return DW'(-181);
    endcase
  endfunction

  // Butterfly sums are DW+1 wide; either halve them or wrap back to DW bits
  function automatic logic signed [DW-1:0] fit(input logic signed [DW:0] s);
    if (SCALE != 0) return DW'(s >>> 1);
    else            return DW'(s);
  endfunction

  always_comb begin
    w_stage = r_cnt[3:2];
    w_bfly  = r_cnt[1:0];
    case (w_stage)
      2'd0: begin
        w_top = {w_bfly, 1'b0};
        w_bot = {w_bfly, 1'b1};
        w_k   = 2'd0;
      end
      2'd1: begin
        w_top = {w_bfly[1], 1'b0, w_bfly[0]};
        w_bot = {w_bfly[1], 1'b1, w_bfly[0]};
        w_k   = {w_bfly[0], 1'b0};
      end
      default: begin
        w_top = {1'b0, w_bfly};
        w_bot = {1'b1, w_bfly};
        w_k   = w_bfly;
      end
    endcase
  end

  assign w_comp    = (r_state == S_COMPUTE);
  assign mult_in_r = w_comp ? r_buf_r[w_bot] : '0;
  assign mult_in_i = w_comp ? r_buf_i[w_bot] : '0;
  assign mult_w_r  = w_comp ? tw_r(w_k) : '0;
  assign mult_w_i  = w_comp ? tw_i(w_k) : '0;

  assign w_ar    = {r_buf_r[w_top][DW-1], r_buf_r[w_top]};
  assign w_ai    = {r_buf_i[w_top][DW-1], r_buf_i[w_top]};
  assign w_pr    = {mult_out_r[DW-1], mult_out_r};
  assign w_pi    = {mult_out_i[DW-1], mult_out_i};
  assign w_sum_r = fit(w_ar + w_pr);
  assign w_sum_i = fit(w_ai + w_pi);
  assign w_dif_r = fit(w_ar - w_pr);
  assign w_dif_i = fit(w_ai - w_pi);

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign out_idx   = r_cnt[2:0];
  assign out_r     = r_buf_r[r_cnt[2:0]];
  assign out_i     = r_buf_i[r_cnt[2:0]];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_LOAD;
      r_cnt       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      for (int n = 0; n < 8; n++) begin
        r_buf_r[n] <= '0;
        r_buf_i[n] <= '0;
      end
    end else begin
      case (r_state)
        S_LOAD: begin
          if (in_valid && r_in_ready) begin
            r_buf_r[bitrev3(r_cnt[2:0])] <= in_r;
            r_buf_i[bitrev3(r_cnt[2:0])] <= in_i;
            if (r_cnt == 4'd7) begin
              r_state    <= S_COMPUTE;
              r_cnt      <= '0;
              r_in_ready <= 1'b0;
              r_busy     <= 1'b1;
            end else begin
              r_cnt <= r_cnt + 4'd1;
            end
          end
        end
        S_COMPUTE: begin
          r_buf_r[w_top] <= w_sum_r;
          r_buf_i[w_top] <= w_sum_i;
          r_buf_r[w_bot] <= w_dif_r;
          r_buf_i[w_bot] <= w_dif_i;
          if (r_cnt == 4'd11) begin
            r_state     <= S_UNLOAD;
            r_cnt       <= '0;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        S_UNLOAD: begin
          if (out_ready) begin
            if (r_cnt == 4'd7) begin
              r_state     <= S_LOAD;
              r_cnt       <= '0;
              r_out_valid <= 1'b0;
              r_in_ready  <= 1'b1;
            end else begin
              r_cnt <= r_cnt + 4'd1;
            end
          end
        end
        default: r_state <= S_LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_fft8_sched.sv
// Bench for fft8_sched: a scaled and an unscaled instance run in lockstep, each with a
// behavioural floor-truncating Q8.8 complex multiplier; results go through a scoreboard.
module tb_fft8_sched;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic signed [DW-1:0] in_r = '0;
  logic signed [DW-1:0] in_i = '0;

  logic in_ready_a, out_valid_a, busy_a;
  logic [2:0] out_idx_a;
  logic signed [DW-1:0] out_r_a, out_i_a, mi_r_a, mi_i_a, mw_r_a, mw_i_a, mo_r_a, mo_i_a;
  logic in_ready_b, out_valid_b, busy_b;
  logic [2:0] out_idx_b;
  logic signed [DW-1:0] out_r_b, out_i_b, mi_r_b, mi_i_b, mw_r_b, mw_i_b, mo_r_b, mo_i_b;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic signed [DW-1:0] cm_r(input logic signed [DW-1:0] ar, ai, wr, wi);
    int p;
    p = int'(ar) * int'(wr) - int'(ai) * int'(wi);
    return DW'(p >>> 8);
  endfunction

  function automatic logic signed [DW-1:0] cm_i(input logic signed [DW-1:0] ar, ai, wr, wi);
    int p;
    p = int'(ar) * int'(wi) + int'(ai) * int'(wr);
    return DW'(p >>> 8);
  endfunction

  assign mo_r_a = cm_r(mi_r_a, mi_i_a, mw_r_a, mw_i_a);
  assign mo_i_a = cm_i(mi_r_a, mi_i_a, mw_r_a, mw_i_a);
  assign mo_r_b = cm_r(mi_r_b, mi_i_b, mw_r_b, mw_i_b);
  assign mo_i_b = cm_i(mi_r_b, mi_i_b, mw_r_b, mw_i_b);

  fft8_sched #(.DW(DW), .SCALE(1)) u_dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready_a), .in_r(in_r), .in_i(in_i),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_r(out_r_a), .out_i(out_i_a),
    .out_idx(out_idx_a), .busy(busy_a),
    .mult_in_r(mi_r_a), .mult_in_i(mi_i_a), .mult_w_r(mw_r_a), .mult_w_i(mw_i_a),
    .mult_out_r(mo_r_a), .mult_out_i(mo_i_a)
  );

  fft8_sched #(.DW(DW), .SCALE(0)) u_dut0 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready_b), .in_r(in_r), .in_i(in_i),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_r(out_r_b), .out_i(out_i_b),
    .out_idx(out_idx_b), .busy(busy_b),
    .mult_in_r(mi_r_b), .mult_in_i(mi_i_b), .mult_w_r(mw_r_b), .mult_w_i(mw_i_b),
    .mult_out_r(mo_r_b), .mult_out_i(mo_i_b)
  );

  // Frames: impulse, DC, alternating, delayed impulse x[1], imaginary impulse
  int fx_r [5][8] = '{
    '{256, 0, 0, 0, 0, 0, 0, 0},
    '{256, 256, 256, 256, 256, 256, 256, 256},
    '{256, -256, 256, -256, 256, -256, 256, -256},
    '{0, 256, 0, 0, 0, 0, 0, 0},
    '{0, 0, 0, 0, 0, 0, 0, 0}};
  int fx_i [5][8] = '{
    '{0, 0, 0, 0, 0, 0, 0, 0},
    '{0, 0, 0, 0, 0, 0, 0, 0},
    '{0, 0, 0, 0, 0, 0, 0, 0},
    '{0, 0, 0, 0, 0, 0, 0, 0},
    '{256, 0, 0, 0, 0, 0, 0, 0}};
  int ex_r [5][8] = '{
    '{32, 32, 32, 32, 32, 32, 32, 32},
    '{256, 0, 0, 0, 0, 0, 0, 0},
    '{0, 0, 0, 0, 256, 0, 0, 0},
    '{32, 22, 0, -23, -32, -23, 0, 23},
    '{0, 0, 0, 0, 0, 0, 0, 0}};
  int ex_i [5][8] = '{
    '{0, 0, 0, 0, 0, 0, 0, 0},
    '{0, 0, 0, 0, 0, 0, 0, 0},
    '{0, 0, 0, 0, 0, 0, 0, 0},
    '{0, -23, -32, -23, 0, 23, 32, 23},
    '{32, 32, 32, 32, 32, 32, 32, 32}};
  int kseq [12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};
  int twr [4] = '{256, 181, 0, -181};
  int twi [4] = '{0, -181, -256, -181};

  typedef struct {
    int idx;
    int r;
    int i;
    bit cb;
    int rb;
    int ib;
  } exp_t;
  exp_t sb[$];

  int n_chk = 0;
  int n_err = 0;
  int acc_edge = 0;

  task automatic chk_eq(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic send_frame(input int f, input bit rnd);
    int n;
    int guard;
    bit acc;
    exp_t e;
    n = 0;
    guard = 0;
    for (int j = 0; j < 8; j++) begin
      e.idx = j;
      e.r   = ex_r[f][j];
      e.i   = ex_i[f][j];
      e.cb  = (f == 0) || (f == 4);
      e.rb  = 8 * ex_r[f][j];
      e.ib  = 8 * ex_i[f][j];
      sb.push_back(e);
    end
    while (n < 8 && guard < 200) begin
      in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      in_r = DW'(fx_r[f][n]);
      in_i = DW'(fx_i[f][n]);
      acc = in_valid && in_ready_a;
      @(posedge clk); #1;
      if (acc) begin
        n++;
        acc_edge = cyc;
      end
      guard++;
    end
    in_valid = 1'b0;
    if (n < 8) chk_eq("send_timeout", n, 8);
  endtask

  task automatic recv_frame(input bit stall);
    int got;
    int guard;
    int stalls;
    int j;
    int pr, pi, pidx;
    bit seen;
    exp_t e;
    got = 0;
    guard = 0;
    stalls = 0;
    seen = 1'b0;
    pr = 0;
    pi = 0;
    pidx = 0;
    // Junk offered while the block is busy must never enter the buffer
    in_valid = 1'b1;
    in_r = 16'sh3579;
    in_i = -16'sh0123;
    while (got < 8 && guard < 400) begin
      j = cyc - acc_edge;
      if (!out_valid_a) begin
        out_ready = 1'b1;
        if (seen) chk_eq("valid_dropped", 0, 1);
        else if (j < 12) begin
          chk_eq("busy", int'(busy_a), 1);
          chk_eq("in_ready_busy", int'(in_ready_a), 0);
          chk_eq("w_r", int'(mw_r_a), twr[kseq[j]]);
          chk_eq("w_i", int'(mw_i_a), twi[kseq[j]]);
        end
      end else begin
        if (!seen) begin
          seen = 1'b1;
          chk_eq("latency", j, 12);
          chk_eq("in_ready_unload", int'(in_ready_a), 0);
          chk_eq("busy_unload", int'(busy_a), 0);
        end
        out_ready = !(stall && got == 3 && stalls < 5);
        if (!out_ready) begin
          if (stalls == 0) begin
            pr = int'(out_r_a);
            pi = int'(out_i_a);
            pidx = int'(out_idx_a);
          end else begin
            chk_eq("hold_r", int'(out_r_a), pr);
            chk_eq("hold_i", int'(out_i_a), pi);
            chk_eq("hold_idx", int'(out_idx_a), pidx);
          end
          stalls++;
        end else if (sb.size() == 0) begin
          chk_eq("sb_underflow", 0, 1);
          got++;
        end else begin
          e = sb.pop_front();
          chk_eq("bin_idx", int'(out_idx_a), e.idx);
          chk_eq("bin_r", int'(out_r_a), e.r);
          chk_eq("bin_i", int'(out_i_a), e.i);
          if (e.cb) begin
            chk_eq("bin_r_noscale", int'(out_r_b), e.rb);
            chk_eq("bin_i_noscale", int'(out_i_b), e.ib);
          end
          got++;
        end
      end
      @(posedge clk); #1;
      guard++;
    end
    out_ready = 1'b0;
    in_valid = 1'b0;
    if (got < 8) chk_eq("recv_timeout", got, 8);
    if (stall) chk_eq("stall_cycles", stalls, 5);
    chk_eq("in_ready_after", int'(in_ready_a), 1);
    chk_eq("out_valid_after", int'(out_valid_a), 0);
  endtask

  task automatic chk_idle(input string tag);
    chk_eq({tag, "_in_ready"}, int'(in_ready_a), 1);
    chk_eq({tag, "_out_valid"}, int'(out_valid_a), 0);
    chk_eq({tag, "_busy"}, int'(busy_a), 0);
    chk_eq({tag, "_out_idx"}, int'(out_idx_a), 0);
    chk_eq({tag, "_w_r"}, int'(mw_r_a), 0);
    chk_eq({tag, "_mult_in_r"}, int'(mi_r_a), 0);
  endtask

  initial begin
    #2 reset = 1'b0;
    #1 chk_idle("reset");
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    send_frame(0, 1'b0);
    recv_frame(1'b0);
    send_frame(1, 1'b1);
    recv_frame(1'b1);
    send_frame(2, 1'b0);
    recv_frame(1'b0);
    send_frame(3, 1'b1);
    recv_frame(1'b0);
    send_frame(4, 1'b0);
    recv_frame(1'b0);

    send_frame(3, 1'b0);
    repeat (6) @(posedge clk);
    #1 reset = 1'b0;
    #1 chk_idle("mid_reset");
    sb.delete();
    @(posedge clk);
    #1 reset = 1'b1;
    send_frame(0, 1'b0);
    recv_frame(1'b0);

    chk_eq("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
